// File: rtl/bht_access_controller_if.sv
// Bundles the fetch lookup, resolve update and table-port signals of the
// branch history table controller. The controller takes the slave view; the
// surrounding fetch/resolve/storage logic (or a bench) takes the master view.
interface bht_access_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_W      = 7
);
    // fetch lookup and prediction response
    logic                  lookup_valid;
    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic                  lookup_ready;
    logic                  pred_valid;
    logic                  pred_taken;
    // resolve-stage updates
    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_addr;
    logic                  upd_taken;
    logic                  upd_ready;
    // single-port table storage
    logic                  mem_en;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_addr;
    logic [1:0]            mem_wdata;
    logic [1:0]            mem_rdata;

    modport slave (
        input  lookup_valid, lookup_addr, upd_valid, upd_addr, upd_taken, mem_rdata,
        output lookup_ready, pred_valid, pred_taken, upd_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output lookup_valid, lookup_addr, upd_valid, upd_addr, upd_taken, mem_rdata,
        input  lookup_ready, pred_valid, pred_taken, upd_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/bht_access_controller.sv
// Branch history table port sequencer: initialisation sweep, lookup/update
// arbitration on the single table port, and a small resolved-update FIFO.
// Updates are read-modify-write (read in RUN, write back in UPD_WR).
module bht_access_controller #(
    parameter int HISTORY_DEPTH  = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int UPD_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic clk_en,
    input  logic flush,
    output logic init_done,
    bht_access_controller_if.slave bus
);
    localparam int IDX_W = $clog2(HISTORY_DEPTH);
    localparam int PTR_W = $clog2(UPD_FIFO_DEPTH);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {INIT, RUN, UPD_WR} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] init_cnt;
    logic [IDX_W-1:0] fifo_idx [UPD_FIFO_DEPTH];
    logic             fifo_tkn [UPD_FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [STV_W-1:0] starve;
    logic [IDX_W-1:0] hold_idx;
    logic             hold_taken;
    logic             pred_q;

    logic             active, op;
    logic             fifo_empty, fifo_full, force_upd;
    logic             accept, pop, push;
    logic [IDX_W-1:0] lookup_idx, upd_idx;
    logic [1:0]       sat_val;

    // Word-aligned PCs: drop the byte offset, ignore bits above the index.
    assign lookup_idx = bus.lookup_addr[IDX_W+1:2];
    assign upd_idx    = bus.upd_addr[IDX_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.lookup_addr[ADDR_WIDTH-1:IDX_W+2], bus.lookup_addr[1:0],
                                bus.upd_addr[ADDR_WIDTH-1:IDX_W+2], bus.upd_addr[1:0]};

    // active: the block is stepping this cycle; op: it may also start port work
    // (a flush cycle only re-arms state and issues nothing).
    assign active = clk_en && !sync_rst;
    assign op     = active && !flush;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign force_upd  = fifo_full || (starve == STV_W'(STARVE_LIMIT));

    assign bus.upd_ready  = op && !fifo_full;
    assign push           = bus.upd_valid && bus.upd_ready;
    assign bus.pred_valid = pred_q && active;
    assign bus.pred_taken = bus.mem_rdata[1];
    assign init_done      = !sync_rst && (state != INIT);

    // Two-bit saturating counter step using the value read in the previous cycle.
    always_comb begin
        sat_val = bus.mem_rdata;
        if (hold_taken) begin
            if (bus.mem_rdata != 2'b11) sat_val = bus.mem_rdata + 2'b01;
        end else begin
            if (bus.mem_rdata != 2'b00) sat_val = bus.mem_rdata - 2'b01;
        end
    end

    // Next state, port arbitration and table-port drive.
    always_comb begin
        state_nxt        = state;
        bus.mem_en       = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = init_cnt;
        bus.mem_wdata    = 2'b01;
        bus.lookup_ready = 1'b0;
        accept           = 1'b0;
        pop              = 1'b0;
        if (op) begin
            case (state)
                INIT: begin
                    bus.mem_en = 1'b1;
                    bus.mem_we = 1'b1;
                    if (init_cnt == IDX_W'(HISTORY_DEPTH - 1)) state_nxt = RUN;
                end
                RUN: begin
                    bus.lookup_ready = !force_upd;
                    if (bus.lookup_valid && !force_upd) begin
                        accept       = 1'b1;
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = lookup_idx;
                    end else if (!fifo_empty) begin
                        pop          = 1'b1;
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = fifo_idx[rd_ptr[PTR_W-1:0]];
                        state_nxt    = UPD_WR;
                    end
                end
                UPD_WR: begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = hold_idx;
                    bus.mem_wdata = sat_val;
                    state_nxt     = RUN;
                end
                default: state_nxt = INIT;
            endcase
        end
        if (active && flush) state_nxt = INIT;
    end

    // Control state: FSM, sweep index, FIFO pointers, starvation count.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state    <= INIT;
            init_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            starve   <= '0;
            pred_q   <= 1'b0;
        end else if (clk_en) begin
            pred_q <= accept;
            state  <= state_nxt;
            if (flush) begin
                init_cnt <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                starve   <= '0;
            end else begin
                if (state == INIT) init_cnt <= init_cnt + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (accept)   starve <= fifo_empty ? '0 : starve + 1'b1;
                else if (pop) starve <= '0;
            end
        end
    end

    // FIFO payload and popped-update holding register (no reset needed; guarded by pointers/state).
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr[PTR_W-1:0]] <= upd_idx;
            fifo_tkn[wr_ptr[PTR_W-1:0]] <= bus.upd_taken;
        end
        if (pop) begin
            hold_idx   <= fifo_idx[rd_ptr[PTR_W-1:0]];
            hold_taken <= fifo_tkn[rd_ptr[PTR_W-1:0]];
        end
    end
endmodule

// File: tb/tb_bht_access_controller.sv
// Bench for bht_access_controller: behavioural table memory, table of
// update/lookup vectors with a prediction scoreboard, and hand sequences for
// FIFO-full, starvation, flush-in-UPD_WR and clk_en stalls.
module tb_bht_access_controller;
    logic clk = 1'b0;
    logic sync_rst, clk_en, flush, init_done;
    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic [1:0] mem [128];

    typedef struct {
        bit          is_upd;
        logic [31:0] addr;
        bit          taken;
        logic [1:0]  exp;   // written counter for updates, table value seen by lookups
    } vec_t;
    vec_t vt[14];

    bht_access_controller_if #(.ADDR_WIDTH(32), .IDX_W(7)) bus ();

    bht_access_controller #(
        .HISTORY_DEPTH(128), .ADDR_WIDTH(32), .UPD_FIFO_DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .flush(flush),
        .init_done(init_done), .bus(bus)
    );

    always #5 clk = ~clk;

    // Table storage: synchronous read, data valid the cycle after the read.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every prediction must match the oldest expectation.
    always begin
        @(posedge clk);
        #3;
        if (bus.pred_valid) begin
            if (exp_q.size() == 0) chk("pred_unexpected", 32'(1), 32'(0));
            else                   chk("pred_taken", 32'(bus.pred_taken), 32'(exp_q.pop_front()));
        end
    end

    task automatic do_upd(input logic [31:0] a, input logic t, input logic [1:0] e);
        bit found;
        found = 0;
        bus.upd_valid = 1'b1; bus.upd_addr = a; bus.upd_taken = t;
        #1 chk("upd_ready", 32'(bus.upd_ready), 32'(1));
        @(negedge clk);
        bus.upd_valid = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            #1;
            if (bus.mem_en && bus.mem_we) begin
                found = 1;
                chk("upd_wr_addr", 32'(bus.mem_addr), 32'(a[8:2]));
                chk("upd_wr_data", 32'(bus.mem_wdata), 32'(e));
            end
            @(negedge clk);
        end
        if (!found) chk("upd_wr_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_lookup(input logic [31:0] a, input logic [1:0] e);
        bus.lookup_valid = 1'b1; bus.lookup_addr = a;
        #1 chk("lookup_ready", 32'(bus.lookup_ready), 32'(1));
        chk("lookup_mem_addr", 32'(bus.mem_addr), 32'(a[8:2]));
        if (bus.lookup_ready) exp_q.push_back(e[1]);
        @(negedge clk);
        bus.lookup_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            #1 chk("sweep", 32'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                   32'({1'b1, 1'b1, 7'(i), 2'b01}));
            @(negedge clk);
        end
    endtask

    initial begin
        int  grants;
        bit  done;
        vt[0]  = '{0, 32'h0000_0040, 0, 2'b01};
        vt[1]  = '{1, 32'h0000_0040, 1, 2'b10};
        vt[2]  = '{1, 32'h0000_0040, 1, 2'b11};
        vt[3]  = '{0, 32'h0000_0040, 0, 2'b11};
        vt[4]  = '{1, 32'h0000_0040, 0, 2'b10};
        vt[5]  = '{1, 32'h0000_0040, 0, 2'b01};
        vt[6]  = '{1, 32'h0000_0040, 0, 2'b00};
        vt[7]  = '{1, 32'h0000_0040, 0, 2'b00};
        vt[8]  = '{0, 32'h0000_0040, 0, 2'b00};
        vt[9]  = '{1, 32'h0000_01FC, 1, 2'b10};
        vt[10] = '{0, 32'h0000_01FC, 0, 2'b10};
        vt[11] = '{0, 32'hFFFF_0040, 0, 2'b00};
        vt[12] = '{1, 32'h0000_0000, 0, 2'b00};
        vt[13] = '{1, 32'h0000_0000, 0, 2'b00};

        sync_rst = 1'b1; clk_en = 1'b1; flush = 1'b0;
        bus.lookup_valid = 1'b0; bus.lookup_addr = '0;
        bus.upd_valid = 1'b0; bus.upd_addr = '0; bus.upd_taken = 1'b0;
        bus.mem_rdata = 2'b00;
        repeat (3) @(negedge clk);
        #1 chk("rst_mem_en", 32'(bus.mem_en), 32'(0));
        chk("rst_init_done", 32'(init_done), 32'(0));
        chk("rst_lookup_ready", 32'(bus.lookup_ready), 32'(0));
        chk("rst_pred_valid", 32'(bus.pred_valid), 32'(0));
        @(negedge clk);
        sync_rst = 1'b0;

        // Initial sweep: 128 consecutive writes of 01, then init_done.
        #1 chk("post_rst_upd_ready", 32'(bus.upd_ready), 32'(1));
        chk("init_lookup_ready", 32'(bus.lookup_ready), 32'(0));
        sweep(0, 128);
        #1 chk("init_done_rise", 32'(init_done), 32'(1));
        chk("idle_after_init", 32'(bus.mem_en), 32'(0));
        @(negedge clk);

        // Table-driven updates and lookups.
        for (int v = 0; v < 14; v++) begin
            if (vt[v].is_upd) do_upd(vt[v].addr, vt[v].taken, vt[v].exp);
            else              do_lookup(vt[v].addr, vt[v].exp);
        end

        // FIFO fill under continuous lookups.
        bus.lookup_valid = 1'b1; bus.lookup_addr = 32'h80;
        for (int c = 0; c < 4; c++) begin
            bus.upd_valid = 1'b1; bus.upd_addr = 32'h100; bus.upd_taken = 1'b1;
            #1 chk("fill_lookup_ready", 32'(bus.lookup_ready), 32'(1));
            chk("fill_upd_ready", 32'(bus.upd_ready), 32'(1));
            if (bus.lookup_ready) exp_q.push_back(1'b0);
            @(negedge clk);
        end
        bus.upd_valid = 1'b0;
        #1 chk("full_lookup_ready", 32'(bus.lookup_ready), 32'(0));
        chk("full_upd_ready", 32'(bus.upd_ready), 32'(0));
        chk("full_pop_rd", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'({1'b1, 1'b0, 7'd64}));
        @(negedge clk);
        #1 chk("updwr_lookup_ready", 32'(bus.lookup_ready), 32'(0));
        chk("updwr_write", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 7'd64, 2'b10}));
        @(negedge clk);
        #1 chk("reassert_lookup_ready", 32'(bus.lookup_ready), 32'(1));
        if (bus.lookup_ready) exp_q.push_back(1'b0);
        @(negedge clk);
        bus.lookup_valid = 1'b0;
        repeat (12) @(negedge clk);
        do_lookup(32'h100, 2'b11);

        // Starvation: one queued update is forced after exactly 8 grants.
        bus.lookup_valid = 1'b1; bus.lookup_addr = 32'h80;
        bus.upd_valid = 1'b1; bus.upd_addr = 32'h0; bus.upd_taken = 1'b1;
        #1 chk("starve_first_ready", 32'(bus.lookup_ready), 32'(1));
        if (bus.lookup_ready) exp_q.push_back(1'b0);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        grants = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (bus.lookup_ready) begin
                grants++;
                exp_q.push_back(1'b0);
            end else begin
                done = 1;
                chk("starve_pop_addr", 32'(bus.mem_addr), 32'(0));
            end
            @(negedge clk);
        end
        bus.lookup_valid = 1'b0;
        chk("starve_grants", 32'(grants), 32'(8));
        repeat (4) @(negedge clk);

        // Flush in UPD_WR with a second update still queued.
        bus.upd_valid = 1'b1; bus.upd_addr = 32'h0; bus.upd_taken = 1'b1;
        @(negedge clk);
        bus.upd_addr = 32'h4;
        #1 chk("flush_pre_read", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'({1'b1, 1'b0, 7'd0}));
        @(negedge clk);
        bus.upd_valid = 1'b0; flush = 1'b1;
        #1 chk("flush_no_write", 32'(bus.mem_we), 32'(0));
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_init_done", 32'(init_done), 32'(0));
        sweep(0, 50);
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("stall_init", 32'({bus.mem_en, bus.lookup_ready, bus.upd_ready, init_done}), 32'(0));
            @(negedge clk);
        end
        clk_en = 1'b1;
        sweep(50, 128);
        #1 chk("reinit_done", 32'(init_done), 32'(1));
        for (int k = 0; k < 3; k++) begin
            #1 chk("flush_fifo_empty", 32'(bus.mem_en), 32'(0));
            @(negedge clk);
        end

        // clk_en stall in RUN with one update queued.
        bus.upd_valid = 1'b1; bus.upd_addr = 32'h8; bus.upd_taken = 1'b1;
        @(negedge clk);
        bus.upd_valid = 1'b0; clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("stall_run", 32'({bus.mem_en, bus.lookup_ready, bus.upd_ready, bus.pred_valid}), 32'(0));
            @(negedge clk);
        end
        clk_en = 1'b1;
        #1 chk("resume_read", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'({1'b1, 1'b0, 7'd2}));
        @(negedge clk);
        #1 chk("resume_write", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 7'd2, 2'b10}));
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bht_access_controller.md
Name: bht_access_controller

Overview:
- Sequences the single-port branch history table (HISTORY_DEPTH x 2-bit saturating counters).
- Arbitrates the one SRAM port between fetch-stage prediction lookups and resolve-stage counter updates; updates are buffered in a small FIFO.
- Runs the table-initialisation sweep after reset and on flush.
- Sits between the fetch unit, the branch-resolve unit and the table storage.

Parameters:
- HISTORY_DEPTH, 128, number of table entries; power of 2, ≥4. IDX_W = $clog2(HISTORY_DEPTH).
- ADDR_WIDTH, 32, branch address width.
- UPD_FIFO_DEPTH, 4, update FIFO entries; power of 2, ≥2.
- STARVE_LIMIT, 8, consecutive lookup grants with the FIFO non-empty before an update is forced.

Ports:
- clk  in  1  clock
- sync_rst  in  1  synchronous reset, active-high
- clk_en  in  1  global enable; when low, all state holds
- flush  in  1  re-initialise the table
- lookup_valid  in  1  fetch lookup request
- lookup_addr  in  ADDR_WIDTH  branch PC to predict
- lookup_ready  out  1  lookup accepted when valid&&ready
- pred_valid  out  1  prediction response
- pred_taken  out  1  predicted direction
- upd_valid  in  1  resolved-branch update
- upd_addr  in  ADDR_WIDTH  resolved branch PC
- upd_taken  in  1  actual outcome
- upd_ready  out  1  FIFO not full
- init_done  out  1  table initialised, lookups serviceable
- mem_en  out  1  table port enable
- mem_we  out  1  table write enable
- mem_addr  out  IDX_W  table index
- mem_wdata  out  2  counter write data
- mem_rdata  in  2  counter read data, valid the cycle after a read

Behaviour:
- Clock and reset: one clock, clk. Reset sync_rst is synchronous and active-high.
- Index mapping: idx = addr[IDX_W+1:2] (word-aligned PCs). Upper address bits are ignored, so aliasing is permitted.
- Counter encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
  - pred_taken = mem_rdata[1].
  - Taken outcome: counter increments, saturating at 11.
  - Not-taken outcome: counter decrements, saturating at 00.
- Reset values:
  - state = INIT, init counter = 0, FIFO empty, starve counter = 0.
  - pred_valid = 0, lookup_ready = 0, init_done = 0, mem_en = 0, mem_we = 0.
  - upd_ready = 1 from the first cycle after reset.
- Registered state on the first cycle after reset: INIT.
- clk_en = 0:
  - FSM, FIFO and counters hold.
  - mem_en = 0, lookup_ready = 0, upd_ready = 0.
  - pred_valid is forced to 0 that cycle.
- FSM states: INIT, RUN, UPD_WR.
  - INIT:
    - Each enabled cycle: mem_en = 1, mem_we = 1, mem_addr = init counter, mem_wdata = 01; the counter increments.
    - After writing index HISTORY_DEPTH-1, go to RUN. The sweep takes exactly HISTORY_DEPTH enabled cycles.
    - lookup_ready = 0. The FIFO still accepts updates.
  - RUN: init_done = 1. Arbitration each cycle:
    - force_upd = FIFO full OR starve counter == STARVE_LIMIT.
    - lookup_ready = !force_upd. It must not depend on lookup_valid.
    - If lookup_valid && lookup_ready: mem_en = 1, mem_we = 0, mem_addr = idx(lookup_addr). pred_valid = 1 next cycle, with pred_taken from mem_rdata. The starve counter increments if the FIFO is non-empty, else clears.
    - Else if the FIFO is non-empty: pop the head into a holding register (idx, taken), mem_en = 1, mem_we = 0, mem_addr = idx, go to UPD_WR, clear the starve counter.
    - Else the port is idle.
  - UPD_WR:
    - mem_en = 1, mem_we = 1, same idx, mem_wdata = sat(mem_rdata, held taken).
    - lookup_ready = 0. Return to RUN.
    - Update throughput is one update per 2 cycles.
- Lookup latency: exactly 1 cycle (accept at N, pred_valid at N+1). Back-to-back lookups are sustained at 1 per cycle.
- Hazards: there is no forwarding from FIFO entries or the in-flight write. A lookup to an index with a pending update returns the pre-update value.
- FIFO:
  - upd_ready = !full.
  - A simultaneous push and pop when full is not allowed, because ready is low when full.
  - A push and pop in the same cycle when non-full are both honoured.
- flush (sampled when clk_en = 1), from any state:
  - Next state is INIT, init counter = 0, FIFO cleared, holding register discarded, starve counter cleared, init_done = 0.
  - An in-flight UPD_WR write is suppressed in the flush cycle; mem_we = 0 that cycle.
  - pred_valid for a lookup accepted in the previous cycle still asserts.
  - flush during INIT restarts the sweep at 0.
- sync_rst overrides flush and clk_en.

Test Plan:
- Reset, then hold clk_en = 1 → mem writes of 01 to indices 0..127 on 128 consecutive cycles; init_done rises on the next cycle; no write occurs to any index twice.
- After init: lookup 0x0000_0040 → lookup_ready = 1, mem_addr = 16, pred_valid = 1 / pred_taken = 0 one cycle later.
- Update 0x40 taken twice, drain, then lookup 0x40 → writes of 10 then 11, pred_taken = 1. Then three not-taken updates → 10, 01, 00. A fourth not-taken update → 00 (saturation).
- Push 4 updates while lookup_valid is held high continuously → lookup_ready falls when the FIFO is full, an update is serviced, and lookup_ready reasserts. With 1 update queued and continuous lookups, the update is forced after exactly 8 lookup grants.
- Assert flush during UPD_WR → no write that cycle; FIFO empty; init sweep restarts at index 0; init_done = 0 until the sweep completes.
- Drop clk_en for 5 cycles mid-INIT and mid-RUN → no mem_en, ready outputs low, state resumes from the same init index / FIFO contents.
